// File: rtl/uart_cmd_sched.sv
// Command sequencer between UART RX and TX: collects header+payload byte pairs,
// updates the config register or streams a response through the TX handshake.
module uart_cmd_sched #(
    parameter int FRAME_SIZE    = 1,
    parameter int CLKS_PER_BIT  = 87,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte,
    input  logic [FRAME_SIZE-1:0] in_message,
    input  logic                  tx_active,
    input  logic                  tx_done,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    output logic [7:0]            cfg_reg,
    output logic                  cfg_valid,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int NB           = (FRAME_SIZE + 7) / 8;
    localparam int SW           = NB * 8;
    localparam int TIMEOUT_CLKS = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
    localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_PAY,
        EXEC,
        SEND,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [1:0]      op;
    logic [5:0]      arg;
    logic [7:0]      payload;
    logic [7:0]      resp;
    logic [SW-1:0]   snap;
    logic [TW-1:0]   timer;
    logic [6:0]      remaining;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state     <= IDLE;
            op        <= '0;
            arg       <= '0;
            payload   <= '0;
            resp      <= '0;
            snap      <= '0;
            timer     <= '0;
            remaining <= '0;
            tx_dv     <= 1'b0;
            tx_byte   <= '0;
            cfg_reg   <= '0;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            tx_dv     <= 1'b0;
            cfg_valid <= 1'b0;
            cmd_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv) begin
                        op    <= rx_byte[7:6];
                        arg   <= rx_byte[5:0];
                        timer <= '0;
                        busy  <= 1'b1;
                        state <= GET_PAY;
                    end
                end
                GET_PAY: begin
                    // A payload arriving on the expiry cycle still completes the command.
                    if (rx_dv) begin
                        payload <= rx_byte;
                        state   <= EXEC;
                    end else if (timer == TW'(TIMEOUT_CLKS - 1)) begin
                        cmd_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                EXEC: begin
                    cmd_err <= rx_dv;
                    case (op)
                        2'b00: begin
                            cfg_reg   <= payload;
                            cfg_valid <= 1'b1;
                            resp      <= 8'hA5;
                            remaining <= 7'd1;
                        end
                        2'b01: begin
                            snap      <= SW'(in_message);
                            remaining <= 7'(NB);
                        end
                        2'b10: begin
                            resp      <= payload;
                            remaining <= {1'b0, arg} + 7'd1;
                        end
                        default: begin
                            resp      <= 8'h5A;
                            remaining <= 7'd1;
                            cmd_err   <= 1'b1;
                        end
                    endcase
                    state <= SEND;
                end
                SEND: begin
                    cmd_err <= rx_dv;
                    if (!tx_active) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= (op == 2'b01) ? snap[7:0] : resp;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    cmd_err <= rx_dv;
                    if (tx_done) begin
                        snap      <= snap >> 8;
                        remaining <= remaining - 7'd1;
                        if (remaining == 7'd1) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed bench for uart_cmd_sched: drives RX byte pairs, plays the transmitter
// side of the TX handshake and checks outputs against hand-computed values.
module tb_uart_cmd_sched;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic [11:0] in_message;
    logic        tx_active;
    logic        tx_done;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [7:0]  cfg_reg;
    logic        cfg_valid;
    logic        busy;
    logic        cmd_err;

    int total = 0;
    int bad   = 0;
    int tx_cnt = 0, err_cnt = 0, cfgv_cnt = 0, viol = 0;
    logic outstanding = 1'b0;

    uart_cmd_sched #(.FRAME_SIZE(12), .CLKS_PER_BIT(87), .TIMEOUT_BYTES(4)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .in_message(in_message), .tx_active(tx_active), .tx_done(tx_done),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .cfg_reg(cfg_reg), .cfg_valid(cfg_valid),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 in_clk = ~in_clk;

    // Pulse counters and single-outstanding-byte tracking, sampled mid-cycle.
    always @(negedge in_clk) begin
        if (in_rst) outstanding = 1'b0;
        if (tx_done === 1'b1) outstanding = 1'b0;
        if (tx_dv === 1'b1) begin
            if (outstanding) viol++;
            outstanding = 1'b1;
            tx_cnt++;
        end
        if (cmd_err === 1'b1) err_cnt++;
        if (cfg_valid === 1'b1) cfgv_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        tick();
        rx_dv   = 1'b0;
    endtask

    task automatic serve_byte(input int hold, output logic [7:0] b);
        int n = 0;
        while (tx_dv !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (tx_dv !== 1'b1) begin
            bad++;
            $display("FAIL serve_wait: tx_dv=%b required 1 within 300 cycles", tx_dv);
            b = 8'hxx;
        end else begin
            b = tx_byte;
            tx_active = 1'b1;
            tick();
            repeat (hold) tick();
            tx_done = 1'b1;
            tick();
            tx_done   = 1'b0;
            tx_active = 1'b0;
        end
    endtask

    task automatic test_reset();
        in_rst = 1'b1; rx_dv = 1'b1; rx_byte = 8'h3F;
        in_message = '0; tx_active = 1'b0; tx_done = 1'b0;
        tick(); tick();
        rx_dv = 1'b0;
        total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL reset_tx_dv: got %b want 0", tx_dv); end
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
        total++; if (cfg_reg !== 8'h00) begin bad++; $display("FAIL reset_cfg_reg: got %h want 00", cfg_reg); end
        total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL reset_cfg_valid: got %b want 0", cfg_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
        in_rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_after_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_cfg();
        int c0 = cfgv_cnt;
        int t0 = tx_cnt;
        send_rx(8'h3F);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wc_busy_hdr: got %b want 1", busy); end
        send_rx(8'hFF);
        total++; if (cfg_reg !== 8'h00) begin bad++; $display("FAIL wc_cfg_at_n: got %h want 00", cfg_reg); end
        tick();
        total++; if (cfg_reg !== 8'hFF) begin bad++; $display("FAIL wc_cfg_n1: got %h want ff", cfg_reg); end
        total++; if (cfg_valid !== 1'b1) begin bad++; $display("FAIL wc_valid_n1: got %b want 1", cfg_valid); end
        total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL wc_txdv_n1: got %b want 0", tx_dv); end
        tick();
        total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL wc_txdv_n2: got %b want 1", tx_dv); end
        total++; if (tx_byte !== 8'hA5) begin bad++; $display("FAIL wc_txbyte: got %h want a5", tx_byte); end
        total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL wc_valid_n2: got %b want 0", cfg_valid); end
        tx_active = 1'b1;
        tick(); tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wc_busy_wait: got %b want 1", busy); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0; tx_active = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wc_busy_done: got %b want 0", busy); end
        tick(); tick();
        total++; if (cfgv_cnt - c0 !== 1) begin bad++; $display("FAIL wc_valid_count: got %0d want 1", cfgv_cnt - c0); end
        total++; if (tx_cnt - t0 !== 1) begin bad++; $display("FAIL wc_tx_count: got %0d want 1", tx_cnt - t0); end
    endtask

    task automatic test_read_msg();
        logic [7:0] b;
        int t0 = tx_cnt;
        in_message = 12'hABC;
        send_rx(8'h40);
        send_rx(8'h00);
        tick();
        in_message = 12'h123;
        serve_byte(3, b);
        total++; if (b !== 8'hBC) begin bad++; $display("FAIL rm_byte0: got %h want bc", b); end
        serve_byte(2, b);
        total++; if (b !== 8'h0A) begin bad++; $display("FAIL rm_byte1: got %h want 0a", b); end
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        total++; if (tx_cnt - t0 !== 2) begin bad++; $display("FAIL rm_tx_count: got %0d want 2", tx_cnt - t0); end
    endtask

    task automatic test_echo();
        logic [7:0] b;
        logic seen = 1'b0;
        int t0 = tx_cnt;
        send_rx(8'h82);
        send_rx(8'h5C);
        serve_byte(1, b);
        total++; if (b !== 8'h5C) begin bad++; $display("FAIL echo_b0: got %h want 5c", b); end
        tx_active = 1'b1;
        repeat (50) begin
            tick();
            if (tx_dv === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL echo_hold: tx_dv seen=%b want 0", seen); end
        tx_active = 1'b0;
        serve_byte(1, b);
        total++; if (b !== 8'h5C) begin bad++; $display("FAIL echo_b1: got %h want 5c", b); end
        serve_byte(1, b);
        total++; if (b !== 8'h5C) begin bad++; $display("FAIL echo_b2: got %h want 5c", b); end
        repeat (5) tick();
        total++; if (tx_cnt - t0 !== 3) begin bad++; $display("FAIL echo_count: got %0d want 3", tx_cnt - t0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL echo_busy: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        int n = 0;
        int e0 = err_cnt;
        int t0 = tx_cnt;
        send_rx(8'h3F);
        while (cmd_err !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        total++; if (n !== 3480) begin bad++; $display("FAIL to_cycles: got %0d want 3480", n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy: got %b want 0", busy); end
        repeat (3) tick();
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL to_err_count: got %0d want 1", err_cnt - e0); end
        total++; if (tx_cnt - t0 !== 0) begin bad++; $display("FAIL to_tx_count: got %0d want 0", tx_cnt - t0); end
        total++; if (cfg_reg !== 8'hFF) begin bad++; $display("FAIL to_cfg_kept: got %h want ff", cfg_reg); end
        send_rx(8'h00);
        send_rx(8'h11);
        tick();
        total++; if (cfg_reg !== 8'h11) begin bad++; $display("FAIL to_cfg_next: got %h want 11", cfg_reg); end
        serve_byte(0, b);
        total++; if (b !== 8'hA5) begin bad++; $display("FAIL to_ack: got %h want a5", b); end
        // payload lands on the exact expiry cycle
        send_rx(8'h3F);
        repeat (3479) tick();
        send_rx(8'h77);
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL to_edge_err: got %b want 0", cmd_err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_edge_busy: got %b want 1", busy); end
        tick();
        total++; if (cfg_reg !== 8'h77) begin bad++; $display("FAIL to_edge_cfg: got %h want 77", cfg_reg); end
        serve_byte(0, b);
        total++; if (b !== 8'hA5) begin bad++; $display("FAIL to_edge_ack: got %h want a5", b); end
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL to_edge_err_count: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_bad_op_overrun();
        int e0 = err_cnt;
        int t0 = tx_cnt;
        send_rx(8'hC0);
        send_rx(8'h00);
        tick();
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL bo_err: got %b want 1", cmd_err); end
        tick();
        total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL bo_txdv: got %b want 1", tx_dv); end
        total++; if (tx_byte !== 8'h5A) begin bad++; $display("FAIL bo_nak: got %h want 5a", tx_byte); end
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL bo_err_clear: got %b want 0", cmd_err); end
        tx_active = 1'b1;
        tick();
        send_rx(8'h99);
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL ov_err: got %b want 1", cmd_err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ov_busy: got %b want 1", busy); end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0; tx_active = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ov_busy_done: got %b want 0", busy); end
        repeat (3) tick();
        total++; if (err_cnt - e0 !== 2) begin bad++; $display("FAIL ov_err_count: got %0d want 2", err_cnt - e0); end
        total++; if (tx_cnt - t0 !== 1) begin bad++; $display("FAIL ov_tx_count: got %0d want 1", tx_cnt - t0); end
        total++; if (tx_byte !== 8'h5A) begin bad++; $display("FAIL ov_tx_byte: got %h want 5a", tx_byte); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int n = 0;
        int t0 = tx_cnt;
        send_rx(8'h83);
        send_rx(8'h21);
        while (tx_dv !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL rst_first_txdv: got %b want 1", tx_dv); end
        tx_active = 1'b1;
        tick();
        in_rst = 1'b1;
        tick();
        total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL rst_tx_dv: got %b want 0", tx_dv); end
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte: got %h want 00", tx_byte); end
        total++; if (cfg_reg !== 8'h00) begin bad++; $display("FAIL rst_cfg_reg: got %h want 00", cfg_reg); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
        total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL rst_cfg_valid: got %b want 0", cfg_valid); end
        in_rst = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0; tx_active = 1'b0;
        repeat (10) tick();
        total++; if (tx_cnt - t0 !== 1) begin bad++; $display("FAIL rst_stray_tx: got %0d want 1", tx_cnt - t0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_stray_busy: got %b want 0", busy); end
        send_rx(8'h00);
        send_rx(8'h42);
        tick();
        total++; if (cfg_reg !== 8'h42) begin bad++; $display("FAIL rst_resume_cfg: got %h want 42", cfg_reg); end
        serve_byte(0, b);
        total++; if (b !== 8'hA5) begin bad++; $display("FAIL rst_resume_ack: got %h want a5", b); end
    endtask

    initial begin
        test_reset();
        test_write_cfg();
        test_read_msg();
        test_echo();
        test_timeout();
        test_bad_op_overrun();
        test_reset_mid();
        repeat (3) tick();
        total++; if (viol !== 0) begin bad++; $display("FAIL single_outstanding: got %0d violations want 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
